// File: rtl/axi4_rd_burst_host_if.sv
// rtl/axi4_rd_burst_host_if.sv - AXI4 read address/data channel interface
// Ports (host view):
//   AR out : aid aaddr alen asize aburst alock acache aprot aregion aqos avalid
//   AR in  : aready
//   R  in  : rid rdata rresp rlast rvalid
//   R  out : rready
interface axi4_rd_intf #(
  parameter int DWIDTH  = 64,
  parameter int AWIDTH  = 32,
  parameter int IDWIDTH = 1
);
  logic [IDWIDTH-1:0] aid;
  logic [AWIDTH-1:0]  aaddr;
  logic [7:0]         alen;
  logic [2:0]         asize;
  logic [1:0]         aburst;
  logic               alock;
  logic [3:0]         acache;
  logic [2:0]         aprot;
  logic [3:0]         aregion;
  logic [3:0]         aqos;
  logic               avalid;
  logic               aready;

  logic [IDWIDTH-1:0] rid;
  logic [DWIDTH-1:0]  rdata;
  logic [1:0]         rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  modport host (
    output aid, aaddr, alen, asize, aburst, alock, acache, aprot, aregion, aqos, avalid,
    input  aready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport agent (
    input  aid, aaddr, alen, asize, aburst, alock, acache, aprot, aregion, aqos, avalid,
    output aready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_rd_burst_host.sv
// rtl/axi4_rd_burst_host.sv - read DMA host splitting commands into 4KB-safe AXI4 INCR bursts
// Optional feature macro: AXI4_RD_RLAST_CHECK_EN (per-burst rlast checking, err[1])
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   cmd_addr/cmd_beats    : command start byte address and total beat count
//   cmd_valid/cmd_ready   : command handshake (ready only while idle)
//   m_data/m_last/m_valid : read data stream, m_last marks final beat of the command
//   m_ready               : downstream ready (passed straight to rready)
//   done                  : one-cycle pulse when the command has fully completed
//   err                   : sticky flags, [0] non-OKAY rresp, [1] rlast mismatch
//   m_axi                 : AXI4 read channels, host side
module axi4_rd_burst_host #(
  parameter int DWIDTH          = 64,
  parameter int AWIDTH          = 32,
  parameter int IDWIDTH         = 1,
  parameter int ARID            = 0,
  parameter int MAX_BURST       = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [15:0]       cmd_beats,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              done,
  output logic [1:0]        err,
  axi4_rd_intf.host         m_axi
);

  localparam int BYTES = DWIDTH / 8;
  localparam int LOG2B = $clog2(BYTES);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [AWIDTH-1:0] ALIGN_MASK = ~(AWIDTH'(BYTES - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ADDR  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_n;

  logic [AWIDTH-1:0] addr_q;
  logic [15:0]       remaining_q;
  logic [15:0]       beats_q;
  logic [15:0]       delivered_q;
  logic [7:0]        alen_q;
  logic [OW-1:0]     outstanding_q;
  logic              done_zero_q;
  logic              err0_q;
  logic              err1;

  logic              avalid;
  logic              cmd_hs;
  logic              ar_hs;
  logic              r_hs;
  logic              burst_end;
  logic              r_end;
  logic              drain_done;
  logic              last_burst;
  logic [12:0]       page_beats;
  logic [8:0]        cap_burst;
  logic [8:0]        len_c;
  logic              unused_rid;

  // Constant AR attributes
  assign m_axi.aid     = IDWIDTH'(ARID);
  assign m_axi.aaddr   = addr_q;
  assign m_axi.alen    = alen_q;
  assign m_axi.asize   = 3'(LOG2B);
  assign m_axi.aburst  = 2'b01;
  assign m_axi.alock   = 1'b0;
  assign m_axi.acache  = 4'b0011;
  assign m_axi.aprot   = 3'b000;
  assign m_axi.aregion = 4'b0000;
  assign m_axi.aqos    = 4'b0000;
  assign m_axi.avalid  = avalid;

  // R channel is a zero-latency pass-through
  assign m_data       = m_axi.rdata;
  assign m_valid      = m_axi.rvalid;
  assign m_axi.rready = m_ready;
  assign m_last       = m_axi.rvalid && (state != IDLE) && (delivered_q == beats_q - 16'd1);

  assign unused_rid = ^m_axi.rid;

  assign cmd_hs = cmd_valid && cmd_ready;
  assign ar_hs  = avalid && m_axi.aready;
  assign r_hs   = m_axi.rvalid && m_ready;
  assign r_end  = r_hs && burst_end;

  // Burst length: smallest of what is left, the burst cap and the beats up to the next 4KB page
  assign page_beats = (13'h1000 - {1'b0, addr_q[11:0]}) >> LOG2B;
  assign cap_burst  = (remaining_q < 16'(MAX_BURST)) ? remaining_q[8:0] : 9'(MAX_BURST);
  assign len_c      = ({4'b0000, cap_burst} < page_beats) ? cap_burst : page_beats[8:0];

  assign last_burst = (remaining_q == (16'(alen_q) + 16'd1));
  assign drain_done = (delivered_q == beats_q) && (outstanding_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    avalid    = 1'b0;
    done      = done_zero_q;
    case (state)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_hs && (cmd_beats != 16'd0)) begin
          state_n = CALC;
        end
      end
      CALC: begin
        state_n = ADDR;
      end
      ADDR: begin
        // Once raised, avalid stays up: outstanding can only fall while we wait
        avalid = (outstanding_q < OW'(MAX_OUTSTANDING));
        if (ar_hs) begin
          state_n = last_burst ? DRAIN : CALC;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      remaining_q   <= '0;
      beats_q       <= '0;
      delivered_q   <= '0;
      alen_q        <= '0;
      outstanding_q <= '0;
      done_zero_q   <= 1'b0;
      err0_q        <= 1'b0;
    end else begin
      done_zero_q <= cmd_hs && (cmd_beats == 16'd0);

      if (cmd_hs) begin
        delivered_q <= '0;
        beats_q     <= cmd_beats;
      end else if (r_hs) begin
        delivered_q <= delivered_q + 16'd1;
      end

      if (cmd_hs) begin
        addr_q      <= cmd_addr & ALIGN_MASK;
        remaining_q <= cmd_beats;
      end else if (ar_hs) begin
        addr_q      <= addr_q + ((AWIDTH'(alen_q) + AWIDTH'(1)) << LOG2B);
        remaining_q <= remaining_q - (16'(alen_q) + 16'd1);
      end

      if (state == CALC) begin
        alen_q <= 8'(len_c - 9'd1);
      end

      case ({ar_hs, r_end})
        2'b10:   outstanding_q <= outstanding_q + OW'(1);
        2'b01:   outstanding_q <= outstanding_q - OW'(1);
        default: outstanding_q <= outstanding_q;
      endcase

      if (r_hs && (m_axi.rresp != 2'b00)) begin
        err0_q <= 1'b1;
      end
    end
  end

`ifdef AXI4_RD_RLAST_CHECK_EN
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [7:0]    len_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    beat_in_burst;
  logic          rlast_err_q;
  logic          exp_last;

  // Burst boundaries come from the issued alen, so a bad rlast cannot skew outstanding
  assign exp_last  = (beat_in_burst == len_fifo[rd_ptr]);
  assign burst_end = exp_last;
  assign err1      = rlast_err_q;

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      len_fifo[wr_ptr] <= alen_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      beat_in_burst <= '0;
      rlast_err_q   <= 1'b0;
    end else begin
      if (ar_hs) begin
        wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (r_hs) begin
        if (exp_last) begin
          beat_in_burst <= '0;
          rd_ptr        <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PW'(1);
        end else begin
          beat_in_burst <= beat_in_burst + 8'd1;
        end
        if (m_axi.rlast != exp_last) begin
          rlast_err_q <= 1'b1;
        end
      end
    end
  end
`else
  assign burst_end = m_axi.rlast;
  assign err1      = 1'b0;
`endif

  assign err = {err1, err0_q};

endmodule

// File: tb/tb_axi4_rd_burst_host.sv
// tb/tb_axi4_rd_burst_host.sv - randomized self-checking bench for axi4_rd_burst_host
module tb_axi4_rd_burst_host;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int IW = 1;
  localparam int MB = 256;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cmd_addr;
  logic [15:0]   cmd_beats;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic          done;
  logic [1:0]    err;

  axi4_rd_intf #(.DWIDTH(DW), .AWIDTH(AW), .IDWIDTH(IW)) axi ();

  axi4_rd_burst_host #(
    .DWIDTH(DW), .AWIDTH(AW), .IDWIDTH(IW), .ARID(0),
    .MAX_BURST(MB), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .done(done), .err(err), .m_axi(axi)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  // Reference: expected AR sequence and data stream of the current command
  burst_t      exp_ar[$];
  logic [63:0] exp_d[$];

  function automatic logic [63:0] dfun(input logic [31:0] a);
    return {a ^ 32'h5A5A_A5A5, a};
  endfunction

  task automatic model_cmd(input logic [31:0] a0, input int beats);
    logic [31:0] base;
    logic [31:0] a;
    int rem;
    int page;
    int len;
    base = a0 & ~32'h7;
    a    = base;
    rem  = beats;
    while (rem > 0) begin
      page = (4096 - int'(a[11:0])) / 8;
      len  = rem;
      if (len > MB)   len = MB;
      if (len > page) len = page;
      exp_ar.push_back('{a, 8'(len - 1)});
      a   = a + 32'(len * 8);
      rem = rem - len;
    end
    for (int i = 0; i < beats; i++) exp_d.push_back(dfun(base + 32'(i * 8)));
  endtask

  // Agent / monitor state
  burst_t      ag_q[$];
  int          rb = 0;
  int          tot_beats = 0;
  int          err_beat = -1;
  int          bad_last = -1;
  bit          withhold = 1'b0;
  int          pa = 100;
  int          pr = 100;
  int          pm = 100;
  int          ar_cnt = 0;
  int unsigned last_hs_cyc = 0;
  int unsigned acc_cyc = 0;

  initial begin : agent
    bit          ar_hs;
    bit          r_hs;
    bit          prev_stall;
    logic [31:0] prev_aaddr;
    logic [7:0]  prev_alen;
    logic [31:0] a;
    burst_t      e;
    logic [63:0] d;
    prev_stall = 1'b0;
    prev_aaddr = '0;
    prev_alen  = '0;
    axi.aready = 1'b0;
    axi.rvalid = 1'b0;
    axi.rdata  = '0;
    axi.rresp  = 2'b00;
    axi.rlast  = 1'b0;
    axi.rid    = '0;
    m_ready    = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = axi.avalid && axi.aready;
      r_hs  = axi.rvalid && axi.rready;
      if (!rst) begin
        check("rready_mirror", 64'(axi.rready), 64'(m_ready));
        check("m_valid_pass", 64'(m_valid), 64'(axi.rvalid));
        if (axi.rvalid) check("m_data_pass", m_data, axi.rdata);
        if (prev_stall) begin
          check("avalid_hold", 64'(axi.avalid), 64'd1);
          check("aaddr_hold", 64'(axi.aaddr), 64'(prev_aaddr));
          check("alen_hold", 64'(axi.alen), 64'(prev_alen));
        end
        if (ag_q.size() >= MO) check("avalid_limit", 64'(axi.avalid), 64'd0);
        if (ar_hs) begin
          ar_cnt++;
          if (exp_ar.size() == 0) begin
            check("ar_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_ar.pop_front();
            check("aaddr", 64'(axi.aaddr), 64'(e.addr));
            check("alen", 64'(axi.alen), 64'(e.len));
          end
          check("asize", 64'(axi.asize), 64'd3);
          check("aburst", 64'(axi.aburst), 64'd1);
          check("acache", 64'(axi.acache), 64'd3);
          check("ar_misc", 64'({axi.aid, axi.alock, axi.aprot, axi.aregion, axi.aqos}), 64'd0);
          ag_q.push_back('{axi.aaddr, axi.alen});
        end
        if (r_hs) begin
          if (exp_d.size() == 0) begin
            check("beat_unexpected", 64'd1, 64'd0);
          end else begin
            d = exp_d.pop_front();
            check("m_data", m_data, d);
            check("m_last", 64'(m_last), 64'(exp_d.size() == 0));
          end
          last_hs_cyc = cyc;
        end
        prev_stall = axi.avalid && !axi.aready;
        prev_aaddr = axi.aaddr;
        prev_alen  = axi.alen;
      end
      @(posedge clk);
      #1;
      if (rst) begin
        ag_q.delete();
        rb         = 0;
        prev_stall = 1'b0;
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'b00;
        axi.aready = 1'b0;
      end else begin
        if (r_hs && ag_q.size() > 0) begin
          tot_beats++;
          if (rb == int'(ag_q[0].len)) begin
            void'(ag_q.pop_front());
            rb = 0;
          end else begin
            rb++;
          end
        end
        if (axi.rvalid && !r_hs) begin
          // hold the pending beat
        end else if (!withhold && ag_q.size() > 0 && ($urandom_range(99) < pr)) begin
          a          = ag_q[0].addr + 32'(rb * 8);
          axi.rvalid = 1'b1;
          axi.rdata  = dfun(a);
          axi.rlast  = (rb == int'(ag_q[0].len)) ||
                       (bad_last >= 0 && rb == bad_last && ag_q[0].len == 8'd7);
          axi.rresp  = (tot_beats == err_beat) ? 2'b10 : 2'b00;
        end else begin
          axi.rvalid = 1'b0;
          axi.rlast  = 1'b0;
          axi.rresp  = 2'b00;
        end
        axi.aready = ($urandom_range(99) < pa);
        m_ready    = ($urandom_range(99) < pm);
      end
    end
  end

  task automatic start_cmd(input logic [31:0] a, input int beats, input string tag, output bit acc);
    model_cmd(a, beats);
    @(posedge clk);
    #1;
    cmd_addr  = a;
    cmd_beats = 16'(beats);
    cmd_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc     = 1'b1;
        acc_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check({tag, "_accept"}, 64'(acc), 64'd1);
  endtask

  task automatic finish_cmd(input string tag, input int beats);
    bit          got;
    int unsigned dcyc;
    got  = 1'b0;
    dcyc = 0;
    for (int n = 0; n < 20000 && !got; n++) begin
      @(negedge clk);
      if (done) begin
        got  = 1'b1;
        dcyc = cyc;
      end
    end
    check({tag, "_done"}, 64'(got), 64'd1);
    if (got) check({tag, "_done_cycle"}, 64'(dcyc),
                   64'((beats == 0) ? acc_cyc + 1 : last_hs_cyc + 1));
    check({tag, "_ar_left"}, 64'(exp_ar.size()), 64'd0);
    check({tag, "_beats_left"}, 64'(exp_d.size()), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    exp_ar.delete();
    exp_d.delete();
  endtask

  task automatic run_cmd(input logic [31:0] a, input int beats, input string tag);
    bit acc;
    start_cmd(a, beats, tag, acc);
    if (acc) finish_cmd(tag, beats);
    else begin
      exp_ar.delete();
      exp_d.delete();
    end
  endtask

  initial begin : main
    int ar0;
    bit acc;
    bit got;
    logic [31:0] ra;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_beats = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_avalid", 64'(axi.avalid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    ar0 = ar_cnt;
    run_cmd(32'h0000_1000, 16, "t1");
    check("t1_ar_count", 64'(ar_cnt - ar0), 64'd1);

    ar0 = ar_cnt;
    run_cmd(32'h0000_0FF0, 4, "t2");
    check("t2_ar_count", 64'(ar_cnt - ar0), 64'd2);

    ar0 = ar_cnt;
    run_cmd(32'h0000_0000, 600, "t3");
    check("t3_ar_count", 64'(ar_cnt - ar0), 64'd3);

    withhold = 1'b1;
    ar0 = ar_cnt;
    start_cmd(32'h0000_0000, 600, "t4", acc);
    repeat (30) @(negedge clk);
    check("t4_ar_held", 64'(ar_cnt - ar0), 64'd2);
    check("t4_avalid_low", 64'(axi.avalid), 64'd0);
    @(posedge clk);
    #1;
    withhold = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      if (ar_cnt - ar0 >= 3) got = 1'b1;
    end
    check("t4_third_ar", 64'(got), 64'd1);
    if (acc) finish_cmd("t4", 600);

    pa = 60;
    pr = 70;
    pm = 50;
    for (int k = 0; k < 6; k++) begin
      ra = $urandom & 32'h0000_FFFF;
      if (k == 0) ra = 32'h0000_1F00 + 32'($urandom_range(31));
      run_cmd(ra, $urandom_range(1, 300), "t5");
    end
    check("t5_err_clean", 64'(err), 64'd0);

    err_beat = tot_beats + 2;
    run_cmd(32'h0000_2000, 8, "t6_resp");
    err_beat = -1;
    check("t6_err_resp", 64'(err), 64'd1);

    ar0 = ar_cnt;
    run_cmd(32'h0000_3000, 0, "t6_zero");
    check("t6_zero_no_ar", 64'(ar_cnt - ar0), 64'd0);
    check("t6_err_sticky", 64'(err), 64'd1);

`ifdef AXI4_RD_RLAST_CHECK_EN
    bad_last = 2;
    run_cmd(32'h0000_4000, 8, "t6_rlast");
    bad_last = -1;
    check("t6_err_rlast", 64'(err), 64'd3);
`else
    run_cmd(32'h0000_4000, 8, "t6_rlast");
    check("t6_err1_tied", 64'(err[1]), 64'd0);
`endif

    start_cmd(32'h0000_0000, 600, "t7", acc);
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_ar.delete();
    exp_d.delete();
    @(negedge clk);
    check("t7_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("t7_rst_avalid", 64'(axi.avalid), 64'd0);
    check("t7_rst_done", 64'(done), 64'd0);
    check("t7_rst_err", 64'(err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t7_ready_after", 64'(cmd_ready), 64'd1);
    run_cmd(32'h0000_0100, 5, "t7_recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
